// File: rtl/btn_mode_sequencer.sv
// Debounced push-button mode selector: commits one one-hot mode per press and holds it.
// Optional BTN_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module btn_mode_sequencer #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] BTN,
   output logic [3:0] btn,
   output logic       mode_valid,
   output logic       mode_chg,
   output logic       busy
);

   // state       | meaning
   // ST_IDLE     | no button seen, waiting for any synchronized press
   // ST_DEBOUNCE | candidate latched, counting stable-high cycles
   // ST_COMMIT   | one cycle: load btn with the candidate
   // ST_RELEASE  | waiting for all buttons released before re-arming
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

   logic [3:0]  sync1_q;
   logic [3:0]  s_q;
   state_t      state_q;
   logic [1:0]  cand_q;
   logic [15:0] cnt_q;
   logic [3:0]  btn_q;
   logic        valid_q;
   logic        chg_q;
   logic        busy_q;
   logic [1:0]  grant_d;
   logic [3:0]  onehot_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 4'b0000;
         s_q     <= 4'b0000;
      end else begin
         sync1_q <= BTN;
         s_q     <= sync1_q;
      end
   end

`ifdef BTN_ROUND_ROBIN_EN
   logic [1:0] last_grant_q;
   logic [1:0] probe;
   logic       found;

   // Search starts one past the previous winner and wraps.
   always_comb begin
      grant_d = 2'd0;
      probe   = 2'd0;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         probe = last_grant_q + 2'(k);
         if (!found && s_q[probe]) begin
            grant_d = probe;
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 2'd3;
      end else if (state_q == ST_COMMIT) begin
         last_grant_q <= cand_q;
      end
   end
`else
   always_comb begin
      if (s_q[0]) begin
         grant_d = 2'd0;
      end else if (s_q[1]) begin
         grant_d = 2'd1;
      end else if (s_q[2]) begin
         grant_d = 2'd2;
      end else begin
         grant_d = 2'd3;
      end
   end
`endif

   assign onehot_d = 4'b0001 << cand_q;

   // busy_q is set alongside each state transition so it mirrors state != IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cand_q  <= 2'd0;
         cnt_q   <= 16'd0;
         btn_q   <= 4'b0000;
         valid_q <= 1'b0;
         chg_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         chg_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s_q != 4'b0000) begin
                  cand_q  <= grant_d;
                  cnt_q   <= 16'd0;
                  state_q <= ST_DEBOUNCE;
                  busy_q  <= 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (!s_q[cand_q]) begin
                  cnt_q   <= 16'd0;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_COMMIT;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            ST_COMMIT: begin
               btn_q   <= onehot_d;
               valid_q <= 1'b1;
               chg_q   <= (onehot_d != btn_q);
               state_q <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (s_q == 4'b0000) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign btn        = btn_q;
   assign mode_valid = valid_q;
   assign mode_chg   = chg_q;
   assign busy       = busy_q;

endmodule
